// File: rtl/ladybird_uart_pkg.sv
// Shared types and constants for the ladybird UART transmit and receive paths.
package ladybird_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;

  // 115200 baud from a 100 MHz clock; both directions must agree on this.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/ladybird_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last cycle.
module ladybird_uart_baud_cnt
  import ladybird_uart_pkg::*;
#(
  parameter int  CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign bit_end = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ladybird_uart_tx.sv
// UART transmitter draining a valid/ready byte source onto a serial line.
// Optional even parity bit is enabled by defining LADYBIRD_UART_TX_PARITY_EN.
module ladybird_uart_tx
  import ladybird_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              txd,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] LAST_DATA    = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP    = BIT_W'(STOP_BITS - 1);

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  baud_cnt;
  logic              bit_end;
  logic              transfer;
`ifdef LADYBIRD_UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign transfer = s_valid && s_ready;

  // Held cleared while idle so every frame starts on a fresh bit period.
  ladybird_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .cnt    (baud_cnt),
    .bit_end(bit_end)
  );

  // s_ready is registered, so it is raised one cycle ahead of the final stop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      txd        <= TXD_IDLE;
      busy       <= 1'b0;
      s_ready    <= 1'b0;
`ifdef LADYBIRD_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state      <= START;
            shreg      <= s_data;
`ifdef LADYBIRD_UART_TX_PARITY_EN
            parity_bit <= ^s_data;
`endif
            bit_idx    <= '0;
            txd        <= TXD_START;
            busy       <= 1'b1;
            s_ready    <= 1'b0;
          end else begin
            txd     <= TXD_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef LADYBIRD_UART_TX_PARITY_EN
              state   <= PARITY;
              txd     <= parity_bit;
`else
              state   <= STOP;
              txd     <= TXD_IDLE;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end

`ifdef LADYBIRD_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            txd     <= TXD_IDLE;
            bit_idx <= '0;
          end
        end
`endif

        STOP: begin
          if (bit_idx == LAST_STOP && baud_cnt == CNT_PRE_LAST) begin
            s_ready <= 1'b1;
          end
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              if (transfer) begin
                state      <= START;
                shreg      <= s_data;
`ifdef LADYBIRD_UART_TX_PARITY_EN
                parity_bit <= ^s_data;
`endif
                txd        <= TXD_START;
                s_ready    <= 1'b0;
              end else begin
                state   <= IDLE;
                txd     <= TXD_IDLE;
                busy    <= 1'b0;
                s_ready <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          txd     <= TXD_IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
